// File: rtl/mtsp_pc_seq_pkg.sv
// Shared definitions for the per-core PC sequencer: branch op codes,
// thread states and the default PC width.
package mtsp_pc_seq_pkg;

    localparam int SIZE_PC_DEF     = 16;
    localparam int STACK_DEPTH_DEF = 4;

    typedef enum logic [3:0] {
        BR_JMP   = 4'h0,
        BR_START = 4'h1,
        BR_END   = 4'h2,
        BR_SEQ   = 4'h3,
        BR_CALL  = 4'h4,
        BR_RET   = 4'h5
    } br_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Codes 0110..1111 carry no action and behave like a sequential step.
    function automatic logic is_redirect_op(input logic [3:0] op);
        return (op == BR_JMP) || (op == BR_START) || (op == BR_END) ||
               (op == BR_CALL) || (op == BR_RET);
    endfunction

endpackage

// File: rtl/mtsp_ras.sv
// Return-address stack: LIFO of link addresses with depth/full/empty status.
// Guards only against self-corruption; overflow/underflow policy lives in the parent.
module mtsp_ras #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DW-1:0]    cnt;
    logic [DW-1:0]    cnt_m1;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign cnt_m1 = cnt - DW'(1);
    assign wr_idx = cnt[AW-1:0];
    assign rd_idx = cnt_m1[AW-1:0];

    assign full  = (cnt == DW'(DEPTH));
    assign empty = (cnt == '0);
    assign depth = cnt;
    assign top   = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            cnt <= '0;
        end else if (push && !full) begin
            mem[wr_idx] <= din;
            cnt         <= cnt + DW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt_m1;
        end
    end

endmodule

// File: rtl/mtsp_pc_seq.sv
// Per-core PC sequencer: owns the architectural PC, issues fetch requests,
// runs the thread run/idle/halt FSM and flushes younger work on redirects.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | thread parked; only START is honoured, no fetch issued
// RUN     | fetching; PC advances on accepted fetch or branch redirect
// HALT    | stack overflow/underflow; ERR held, START or END exits
module mtsp_pc_seq
    import mtsp_pc_seq_pkg::*;
#(
    parameter int SIZE_PC     = SIZE_PC_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           PC_nEN,
    input  logic [3:0]                     PC_BO,
    input  logic [SIZE_PC-1:0]             PC_NEXT,
    input  logic [SIZE_PC-1:0]             PC_LINK,
    output logic                           FETCH_VALID,
    input  logic                           FETCH_READY,
    output logic [SIZE_PC-1:0]             FETCH_PC,
    output logic                           FLUSH,
    output logic                           BUSY,
    output logic                           ERR,
    output logic [$clog2(STACK_DEPTH):0]   SP
);

    state_e             state;
    logic [SIZE_PC-1:0] pc;
    logic               flush;
    logic               err;

    logic               br_req;
    logic               in_run;
    logic               ras_push;
    logic               ras_pop;
    logic               ras_clear;
    logic [SIZE_PC-1:0] ras_top;
    logic               ras_full;
    logic               ras_empty;

    assign br_req = ~PC_nEN;
    assign in_run = (state == ST_RUN);

    // Stack side effects are qualified here so the RAS never sees an illegal op.
    assign ras_push  = in_run && br_req && (PC_BO == BR_CALL) && !ras_full;
    assign ras_pop   = in_run && br_req && (PC_BO == BR_RET) && !ras_empty;
    assign ras_clear = br_req && ((PC_BO == BR_START) ||
                                  ((PC_BO == BR_END) && (state != ST_IDLE)));

    mtsp_ras #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (SIZE_PC)
    ) u_ras (
        .clk   (CLK),
        .rst   (RST),
        .push  (ras_push),
        .pop   (ras_pop),
        .clear (ras_clear),
        .din   (PC_LINK),
        .top   (ras_top),
        .depth (SP),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            pc    <= '0;
            flush <= 1'b0;
            err   <= 1'b0;
        end else begin
            flush <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (br_req && (PC_BO == BR_START)) begin
                        pc    <= PC_NEXT;
                        err   <= 1'b0;
                        state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    // A branch beats a coincident fetch accept; the FLUSH kills that fetch.
                    if (br_req && is_redirect_op(PC_BO)) begin
                        flush <= 1'b1;
                        case (PC_BO)
                            BR_JMP, BR_START: begin
                                pc <= PC_NEXT;
                            end
                            BR_CALL: begin
                                if (ras_full) begin
                                    err   <= 1'b1;
                                    state <= ST_HALT;
                                end else begin
                                    pc <= PC_NEXT;
                                end
                            end
                            BR_RET: begin
                                if (ras_empty) begin
                                    err   <= 1'b1;
                                    state <= ST_HALT;
                                end else begin
                                    pc <= ras_top;
                                end
                            end
                            BR_END: begin
                                state <= ST_IDLE;
                            end
                            default: begin
                                pc <= pc;
                            end
                        endcase
                    end else if (FETCH_READY) begin
                        pc <= pc + SIZE_PC'(1);
                    end
                end

                ST_HALT: begin
                    if (br_req && (PC_BO == BR_START)) begin
                        pc    <= PC_NEXT;
                        err   <= 1'b0;
                        state <= ST_RUN;
                    end else if (br_req && (PC_BO == BR_END)) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign FETCH_VALID = in_run;
    assign FETCH_PC    = pc;
    assign BUSY        = (state != ST_IDLE);
    assign FLUSH       = flush;
    assign ERR         = err;

endmodule

// File: tb/tb_mtsp_pc_seq.sv
// Bench for mtsp_pc_seq: directed vector table, async-reset sequences and a
// randomized run against a queue-based reference model.
module tb_mtsp_pc_seq;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rst;
    logic         pc_nen;
    logic [3:0]   pc_bo;
    logic [W-1:0] pc_next;
    logic [W-1:0] pc_link;
    logic         fetch_valid;
    logic         fetch_ready;
    logic [W-1:0] fetch_pc;
    logic         flush;
    logic         busy;
    logic         err;
    logic [2:0]   sp;

    int total = 0;
    int bad   = 0;

    mtsp_pc_seq #(.SIZE_PC(W), .STACK_DEPTH(DEPTH)) dut (
        .CLK         (clk),
        .RST         (rst),
        .PC_nEN      (pc_nen),
        .PC_BO       (pc_bo),
        .PC_NEXT     (pc_next),
        .PC_LINK     (pc_link),
        .FETCH_VALID (fetch_valid),
        .FETCH_READY (fetch_ready),
        .FETCH_PC    (fetch_pc),
        .FLUSH       (flush),
        .BUSY        (busy),
        .ERR         (err),
        .SP          (sp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         nen;
        logic [3:0]   bo;
        logic [W-1:0] nxt;
        logic [W-1:0] lnk;
        logic         rdy;
        logic         e_valid;
        logic [W-1:0] e_pc;
        logic         e_flush;
        logic         e_busy;
        logic         e_err;
        logic [2:0]   e_sp;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic nen, logic [3:0] bo, logic [W-1:0] nxt, logic [W-1:0] lnk,
                                logic rdy, logic ev, logic [W-1:0] epc, logic ef, logic eb,
                                logic ee, logic [2:0] esp);
        vec_t v;
        v.nen = nen; v.bo = bo; v.nxt = nxt; v.lnk = lnk; v.rdy = rdy;
        v.e_valid = ev; v.e_pc = epc; v.e_flush = ef; v.e_busy = eb; v.e_err = ee; v.e_sp = esp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic nen, input logic [3:0] bo, input logic [W-1:0] nxt,
                         input logic [W-1:0] lnk, input logic rdy);
        pc_nen = nen; pc_bo = bo; pc_next = nxt; pc_link = lnk; fetch_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [W-1:0] p, input logic f,
                           input logic b, input logic e, input logic [2:0] s, input logic s_known);
        chk({tag, ".valid"}, 32'(fetch_valid), 32'(v));
        chk({tag, ".pc"},    32'(fetch_pc),    32'(p));
        chk({tag, ".flush"}, 32'(flush),       32'(f));
        chk({tag, ".busy"},  32'(busy),        32'(b));
        chk({tag, ".err"},   32'(err),         32'(e));
        if (s_known) chk({tag, ".sp"}, 32'(sp), 32'(s));
    endtask

    // Reference model: mode 0=idle 1=run 2=halt, stack as a queue.
    int           m_mode;
    logic [W-1:0] m_pc;
    logic [W-1:0] m_stack[$];
    logic         m_err;
    logic         m_flush;
    logic         m_sp_known;

    task automatic model_reset();
        m_mode = 0; m_pc = '0; m_stack.delete(); m_err = 0; m_flush = 0; m_sp_known = 1;
    endtask

    task automatic model_step(input logic nen, input logic [3:0] bo, input logic [W-1:0] nxt,
                              input logic [W-1:0] lnk, input logic rdy);
        logic req;
        req = !nen;
        m_flush = 0;
        if (m_mode == 0) begin
            if (req && bo == 4'd1) begin
                m_pc = nxt; m_stack.delete(); m_err = 0; m_mode = 1; m_sp_known = 1;
            end
        end else if (m_mode == 1) begin
            if (req && bo == 4'd0) begin
                m_pc = nxt; m_flush = 1;
            end else if (req && bo == 4'd1) begin
                m_pc = nxt; m_stack.delete(); m_flush = 1;
            end else if (req && bo == 4'd2) begin
                m_mode = 0; m_stack.delete(); m_flush = 1;
            end else if (req && bo == 4'd4) begin
                m_flush = 1;
                if (m_stack.size() == DEPTH) begin
                    m_err = 1; m_mode = 2;
                end else begin
                    m_stack.push_back(lnk); m_pc = nxt;
                end
            end else if (req && bo == 4'd5) begin
                m_flush = 1;
                if (m_stack.size() == 0) begin
                    m_err = 1; m_mode = 2;
                end else begin
                    m_pc = m_stack.pop_back();
                end
            end else if (rdy) begin
                m_pc = W'((int'(m_pc) + 1) % (1 << W));
            end
        end else begin
            if (req && bo == 4'd1) begin
                m_pc = nxt; m_stack.delete(); m_err = 0; m_mode = 1; m_sp_known = 1;
            end else if (req && bo == 4'd2) begin
                m_mode = 0; m_sp_known = 0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        pc_nen = 1'b1; pc_bo = 4'd3; pc_next = '0; pc_link = '0; fetch_ready = 1'b0;

        // Directed table: JMP=0 START=1 END=2 SEQ=3 CALL=4 RET=5
        tv.push_back(mk(0, 4'd1, 16'h0100, 0,      1, 1, 16'h0100, 0, 1, 0, 0));
        tv.push_back(mk(1, 4'd3, 0,        0,      1, 1, 16'h0101, 0, 1, 0, 0));
        tv.push_back(mk(1, 4'd3, 0,        0,      1, 1, 16'h0102, 0, 1, 0, 0));
        tv.push_back(mk(1, 4'd3, 0,        0,      1, 1, 16'h0103, 0, 1, 0, 0));
        tv.push_back(mk(1, 4'd3, 0,        0,      1, 1, 16'h0104, 0, 1, 0, 0));
        tv.push_back(mk(1, 4'd3, 0,        0,      1, 1, 16'h0105, 0, 1, 0, 0));
        tv.push_back(mk(1, 4'd3, 0,        0,      0, 1, 16'h0105, 0, 1, 0, 0));
        tv.push_back(mk(1, 4'd3, 0,        0,      0, 1, 16'h0105, 0, 1, 0, 0));
        tv.push_back(mk(1, 4'd3, 0,        0,      0, 1, 16'h0105, 0, 1, 0, 0));
        tv.push_back(mk(0, 4'd0, 16'h0200, 0,      0, 1, 16'h0200, 1, 1, 0, 0));
        tv.push_back(mk(1, 4'd3, 0,        0,      0, 1, 16'h0200, 0, 1, 0, 0));
        tv.push_back(mk(0, 4'd4, 16'h0300, 16'h0111, 1, 1, 16'h0300, 1, 1, 0, 1));
        tv.push_back(mk(1, 4'd3, 0,        0,      1, 1, 16'h0301, 0, 1, 0, 1));
        tv.push_back(mk(0, 4'd5, 16'hDEAD, 0,      1, 1, 16'h0111, 1, 1, 0, 0));
        tv.push_back(mk(0, 4'd9, 16'hBEEF, 0,      1, 1, 16'h0112, 0, 1, 0, 0));
        tv.push_back(mk(0, 4'd3, 16'hBEEF, 0,      0, 1, 16'h0112, 0, 1, 0, 0));
        tv.push_back(mk(0, 4'd4, 16'h0400, 16'h0500, 1, 1, 16'h0400, 1, 1, 0, 1));
        tv.push_back(mk(0, 4'd4, 16'h0401, 16'h0501, 1, 1, 16'h0401, 1, 1, 0, 2));
        tv.push_back(mk(0, 4'd4, 16'h0402, 16'h0502, 1, 1, 16'h0402, 1, 1, 0, 3));
        tv.push_back(mk(0, 4'd4, 16'h0403, 16'h0503, 1, 1, 16'h0403, 1, 1, 0, 4));
        tv.push_back(mk(0, 4'd4, 16'h0777, 16'h0504, 1, 0, 16'h0403, 1, 1, 1, 4));
        tv.push_back(mk(1, 4'd3, 0,        0,      1, 0, 16'h0403, 0, 1, 1, 4));
        tv.push_back(mk(0, 4'd1, 16'h0000, 0,      1, 1, 16'h0000, 0, 1, 0, 0));
        tv.push_back(mk(0, 4'd5, 16'h0040, 0,      1, 0, 16'h0000, 1, 1, 1, 0));
        tv.push_back(mk(0, 4'd1, 16'hFFFE, 0,      1, 1, 16'hFFFE, 0, 1, 0, 0));
        tv.push_back(mk(1, 4'd3, 0,        0,      1, 1, 16'hFFFF, 0, 1, 0, 0));
        tv.push_back(mk(1, 4'd3, 0,        0,      1, 1, 16'h0000, 0, 1, 0, 0));
        tv.push_back(mk(0, 4'd2, 16'h0555, 0,      1, 0, 16'h0000, 1, 0, 0, 0));
        tv.push_back(mk(1, 4'd3, 0,        0,      1, 0, 16'h0000, 0, 0, 0, 0));
        tv.push_back(mk(0, 4'd0, 16'h1234, 0,      1, 0, 16'h0000, 0, 0, 0, 0));
        tv.push_back(mk(0, 4'd1, 16'h0010, 0,      1, 1, 16'h0010, 0, 1, 0, 0));
        tv.push_back(mk(0, 4'd5, 16'h0000, 0,      1, 0, 16'h0010, 1, 1, 1, 0));
        tv.push_back(mk(0, 4'd2, 16'h0000, 0,      1, 0, 16'h0010, 0, 0, 1, 0));

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 16'h0000, 0, 0, 0, 0, 1);
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].nen, tv[i].bo, tv[i].nxt, tv[i].lnk, tv[i].rdy);
            chk_all($sformatf("vec%0d", i), tv[i].e_valid, tv[i].e_pc, tv[i].e_flush,
                    tv[i].e_busy, tv[i].e_err, tv[i].e_sp, 1);
        end

        // Async reset while FLUSH is high and the stack is populated.
        drive(0, 4'd1, 16'h0A00, 0, 1);
        drive(0, 4'd4, 16'h0B00, 16'h0A01, 1);
        chk("mid.flush_pre", 32'(flush), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 16'h0000, 0, 0, 0, 0, 1);
        // START presented during reset must be lost.
        pc_nen = 1'b0; pc_bo = 4'd1; pc_next = 16'h0C00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 4'd3, 0, 0, 1);
        chk_all("rst_lost_start", 0, 16'h0000, 0, 0, 0, 0, 1);

        // Randomized run against the reference model.
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            logic         nen;
            logic [3:0]   bo;
            logic [W-1:0] nxt;
            logic [W-1:0] lnk;
            logic         rdy;
            int           r;
            r = $urandom_range(0, 15);
            case (r)
                0, 1:       bo = 4'd0;
                2, 3, 4:    bo = 4'd1;
                5:          bo = 4'd2;
                6, 7:       bo = 4'd3;
                8, 9, 10:   bo = 4'd4;
                11, 12:     bo = 4'd5;
                default:    bo = 4'(r);
            endcase
            nen = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            nxt = W'($urandom);
            if (n % 97 == 0) nxt = 16'hFFFD;
            lnk = W'($urandom);
            rdy = 1'($urandom_range(0, 3) != 0);
            drive(nen, bo, nxt, lnk, rdy);
            model_step(nen, bo, nxt, lnk, rdy);
            chk_all($sformatf("rnd%0d", n), (m_mode == 1), m_pc, m_flush, (m_mode != 0),
                    m_err, 3'(m_stack.size()), m_sp_known);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
